scoreboard_regfile: RTL and testbench

Parametrised multi-read, dual-write register file with per-register busy scoreboard and write-to-read bypass, for the pipelined/dual-issue core. It replaces the fixed 2R1W negedge-write file: writes commit on the rising edge, same-cycle write data is forwarded to readers, and a busy bit per register tracks outstanding producers for hazard detection in decode. After reset it clears all registers through a sequential sweep and reports readiness.

---
 rtl/scoreboard_regfile.sv | 182 ++++++++++++++++++
 tb/tb_scoreboard_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: multi-read, dual-write register file with a per-register
// busy scoreboard and same-cycle write-to-read bypass.
// After reset, a sequential sweep clears every register. Traffic is accepted
// only once the sweep has finished and the file is in RUN.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   readAddr     READ_PORTS packed read addresses
//   readData     READ_PORTS packed read data (combinational)
//   readBusy     per-read-port busy flag (combinational)
//   writeEnable  per-write-port enable (2 ports)
//   writeAddr    2 packed write addresses
//   writeData    2 packed write data words
//   issueValid   mark issueAddr busy (new producer issued)
//   issueAddr    destination register being issued
//   ready        1 when the sweep is done and the file is in RUN

// One read port: zero-register and range handling, bypass, and busy masking.
module scoreboard_regfile_rdport #(
  parameter int WORD_LEN      = 32,
  parameter int REG_COUNT     = 32,
  parameter int REG_IDX_WIDTH = $clog2(REG_COUNT),
  parameter int ZERO_REG      = 1
) (
  input  logic                                 active,
  input  logic [REG_IDX_WIDTH-1:0]             addr,
  input  logic [REG_COUNT-1:0][WORD_LEN-1:0]   regFile,
  input  logic [REG_COUNT-1:0]                 busyVec,
  input  logic [1:0]                           writeEnable,
  input  logic [1:0][REG_IDX_WIDTH-1:0]        wrAddr,
  input  logic [1:0][WORD_LEN-1:0]            wrData,
  output logic [WORD_LEN-1:0]                  data,
  output logic                                 busy
);
  logic inRange, isZero, byp0, byp1;

  // The compare is widened by one bit so it stays meaningful when
  // REG_COUNT is a power of two.
  assign inRange = {1'b0, addr} < (REG_IDX_WIDTH+1)'(REG_COUNT);
  assign isZero  = (ZERO_REG != 0) && (addr == '0);
  assign byp0    = writeEnable[0] && (wrAddr[0] == addr);
  assign byp1    = writeEnable[1] && (wrAddr[1] == addr);

  always_comb begin
    data = '0;
    busy = 1'b0;
    if (active && inRange && !isZero) begin
      if (byp1)      data = wrData[1];
      else if (byp0) data = wrData[0];
      else           data = regFile[addr];
      // A write in this cycle retires the producer, so the consumer may
      // take the bypassed value now.
      busy = busyVec[addr] && !(byp0 || byp1);
    end
  end
endmodule

module scoreboard_regfile #(
  parameter int WORD_LEN      = 32,
  parameter int REG_COUNT     = 32,
  parameter int REG_IDX_WIDTH = $clog2(REG_COUNT),
  parameter int READ_PORTS    = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [READ_PORTS*REG_IDX_WIDTH-1:0] readAddr,
  output logic [READ_PORTS*WORD_LEN-1:0]      readData,
  output logic [READ_PORTS-1:0]               readBusy,
  input  logic [1:0]                          writeEnable,
  input  logic [2*REG_IDX_WIDTH-1:0]          writeAddr,
  input  logic [2*WORD_LEN-1:0]               writeData,
  input  logic                                issueValid,
  input  logic [REG_IDX_WIDTH-1:0]            issueAddr,
  output logic                                ready
);
  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [REG_IDX_WIDTH-1:0] LAST_IDX = REG_IDX_WIDTH'(REG_COUNT-1);

  state_t                                 state, stateNext;
  logic [REG_IDX_WIDTH-1:0]               sweepIdx, sweepNext;
  logic                                   active;
  logic [REG_COUNT-1:0][WORD_LEN-1:0]     regs;
  logic [REG_COUNT-1:0]                   busy;
  logic [1:0][REG_IDX_WIDTH-1:0]          wrAddr;
  logic [1:0][WORD_LEN-1:0]               wrData;
  logic [READ_PORTS-1:0][REG_IDX_WIDTH-1:0] rdAddr;
  logic [READ_PORTS-1:0][WORD_LEN-1:0]    rdData;

  assign wrAddr   = writeAddr;
  assign wrData   = writeData;
  assign rdAddr   = readAddr;
  assign readData = rdData;

  // Outputs are gated by rst directly, so they read zero during the reset
  // cycle even if the state register still holds RUN.
  assign active = (state == RUN) && !rst;
  assign ready  = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      sweepIdx <= '0;
    end else begin
      state    <= stateNext;
      sweepIdx <= sweepNext;
    end
  end

  always_comb begin
    stateNext = state;
    sweepNext = sweepIdx;
    case (state)
      CLEAR: begin
        sweepNext = sweepIdx + REG_IDX_WIDTH'(1);
        if (sweepIdx == LAST_IDX) stateNext = RUN;
      end
      RUN: ;
      default: stateNext = CLEAR;
    endcase
  end

  // Per-register storage and scoreboard bit. Out-of-range write and issue
  // addresses match no register and are therefore dropped.
  for (genvar r = 0; r < REG_COUNT; r++) begin : gReg
    localparam logic [REG_IDX_WIDTH-1:0] R = REG_IDX_WIDTH'(r);
    localparam bit WRITABLE = !((ZERO_REG != 0) && (r == 0));

    logic                hit0, hit1, issueHit;
    logic [WORD_LEN-1:0] regQ;
    logic                busyQ;

    assign hit0     = WRITABLE && writeEnable[0] && (wrAddr[0] == R);
    assign hit1     = WRITABLE && writeEnable[1] && (wrAddr[1] == R);
    assign issueHit = WRITABLE && issueValid && (issueAddr == R);

    always_ff @(posedge clk) begin
      if (!rst) begin
        if (state == CLEAR) begin
          if (sweepIdx == R) regQ <= '0;
        end else if (hit1) begin
          regQ <= wrData[1];
        end else if (hit0) begin
          regQ <= wrData[0];
        end
      end
    end

    // A new issue outranks a retiring write to the same register: the
    // write belongs to the older producer.
    always_ff @(posedge clk) begin
      if (rst) busyQ <= 1'b0;
      else if (state == RUN) begin
        if (issueHit)          busyQ <= 1'b1;
        else if (hit0 || hit1) busyQ <= 1'b0;
      end
    end

    assign regs[r] = regQ;
    assign busy[r] = busyQ;
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : gRd
    scoreboard_regfile_rdport #(
      .WORD_LEN      (WORD_LEN),
      .REG_COUNT     (REG_COUNT),
      .REG_IDX_WIDTH (REG_IDX_WIDTH),
      .ZERO_REG      (ZERO_REG)
    ) uRd (
      .active      (active),
      .addr        (rdAddr[k]),
      .regFile     (regs),
      .busyVec     (busy),
      .writeEnable (writeEnable),
      .wrAddr      (wrAddr),
      .wrData      (wrData),
      .data        (rdData[k]),
      .busy        (readBusy[k])
    );
  end
endmodule

// File: tb/tb_scoreboard_regfile.sv
module tb_scoreboard_regfile;
  localparam int W   = 32;
  localparam int N   = 32;
  localparam int IDX = 5;
  localparam int RP  = 2;
  localparam int NV  = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic [RP*IDX-1:0] readAddr;
  logic [RP*W-1:0]   readData;
  logic [RP-1:0]     readBusy;
  logic [1:0]        writeEnable;
  logic [2*IDX-1:0]  writeAddr;
  logic [2*W-1:0]    writeData;
  logic              issueValid;
  logic [IDX-1:0]    issueAddr;
  logic              ready;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  scoreboard_regfile #(
    .WORD_LEN(W), .REG_COUNT(N), .REG_IDX_WIDTH(IDX), .READ_PORTS(RP), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .readAddr(readAddr), .readData(readData),
    .readBusy(readBusy), .writeEnable(writeEnable), .writeAddr(writeAddr),
    .writeData(writeData), .issueValid(issueValid), .issueAddr(issueAddr),
    .ready(ready)
  );

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;   // {busy1, busy0}
  } vec_t;

  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeEnable = 2'b00;
    writeAddr   = '0;
    writeData   = '0;
    issueValid  = 1'b0;
    issueAddr   = '0;
  endtask

  task automatic applyVec(input vec_t v);
    writeEnable = v.wen;
    writeAddr   = {v.wa1, v.wa0};
    writeData   = {v.wd1, v.wd0};
    issueValid  = v.iss;
    issueAddr   = v.ia;
    readAddr    = {v.ra1, v.ra0};
  endtask

  // Called just after an edge that sampled rst high, with rst now low.
  // Counts cycles with ready low; optionally drives traffic mid-sweep.
  task automatic waitReady(input bit traffic, output int n);
    n = 0;
    while (n < 200) begin
      if (traffic && n == 5) begin
        writeEnable = 2'b11;
        writeAddr   = {5'd13, 5'd12};
        writeData   = {32'h00000088, 32'h00000077};
        issueValid  = 1'b1;
        issueAddr   = 5'd14;
        readAddr    = {5'd13, 5'd12};
      end else begin
        idle();
      end
      #1;
      if (ready) break;
      if (traffic && n == 5) begin
        chk("clearRd0", readData[31:0], 32'h0);
        chk("clearRd1", readData[63:32], 32'h0);
        chk("clearBusy", {30'b0, readBusy}, 32'h0);
      end
      n++;
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{2'b01, 5'd5,  5'd0,  32'h12345678, 32'h0, 1'b0, 5'd0,  5'd5,  5'd6,  32'h12345678, 32'h0, 2'b00};
    vecs[1]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd5,  5'd0,  32'h12345678, 32'h0, 2'b00};
    vecs[2]  = '{2'b11, 5'd7,  5'd7,  32'hAAAA0000, 32'h5555FFFF, 1'b0, 5'd0, 5'd7, 5'd5, 32'h5555FFFF, 32'h12345678, 2'b00};
    vecs[3]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd7,  5'd7,  32'h5555FFFF, 32'h5555FFFF, 2'b00};
    vecs[4]  = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    vecs[5]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd0,  5'd3,  32'h0, 32'h0, 2'b00};
    vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b1, 5'd3,  5'd3,  5'd3,  32'h0, 32'h0, 2'b00};
    vecs[7]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd3,  5'd5,  32'h0, 32'h12345678, 2'b01};
    vecs[8]  = '{2'b10, 5'd0,  5'd3,  32'h0, 32'hCAFEF00D, 1'b0, 5'd0, 5'd3, 5'd3, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00};
    vecs[9]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd3,  5'd7,  32'hCAFEF00D, 32'h5555FFFF, 2'b00};
    vecs[10] = '{2'b01, 5'd3,  5'd0,  32'h11112222, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h11112222, 32'h11112222, 2'b00};
    vecs[11] = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd3,  5'd3,  32'h11112222, 32'h11112222, 2'b11};
    vecs[12] = '{2'b01, 5'd3,  5'd0,  32'h33334444, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9, 32'h33334444, 32'h0, 2'b00};
    vecs[13] = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd3,  5'd9,  32'h33334444, 32'h0, 2'b00};
    vecs[14] = '{2'b11, 5'd10, 5'd11, 32'h0000000A, 32'h0000000B, 1'b1, 5'd9, 5'd10, 5'd11, 32'h0000000A, 32'h0000000B, 2'b00};
    vecs[15] = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd9,  5'd11, 32'h0, 32'h0000000B, 2'b01};
    vecs[16] = '{2'b01, 5'd9,  5'd0,  32'h99999999, 32'h0, 1'b1, 5'd12, 5'd12, 5'd9, 32'h0, 32'h99999999, 2'b00};
    vecs[17] = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 5'd0,  5'd12, 5'd9,  32'h0, 32'h99999999, 2'b01};

    // Reset state
    rst = 1'b1;
    readAddr = {5'd2, 5'd1};
    idle();
    tick();
    chk("rstReady", {31'b0, ready}, 32'h0);
    chk("rstRd0", readData[31:0], 32'h0);
    chk("rstBusy", {30'b0, readBusy}, 32'h0);
    rst = 1'b0;
    waitReady(1'b0, n);
    chk("initSweepLatency", n, 32);

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      applyVec(vecs[i]);
      #1;
      chk($sformatf("vec%0d rd0", i), readData[31:0], vecs[i].e0);
      chk($sformatf("vec%0d rd1", i), readData[63:32], vecs[i].e1);
      chk($sformatf("vec%0d busy", i), {30'b0, readBusy}, {30'b0, vecs[i].eb});
      chk($sformatf("vec%0d ready", i), {31'b0, ready}, 32'h1);
      tick();
    end
    idle();

    // Preload every register with DEADBEEF (x0 stays 0)
    for (int i = 0; i < N; i += 2) begin
      writeEnable = 2'b11;
      writeAddr   = {5'(i + 1), 5'(i)};
      writeData   = {32'hDEADBEEF, 32'hDEADBEEF};
      tick();
    end
    idle();
    for (int i = 0; i < N; i += 2) begin
      readAddr = {5'(i + 1), 5'(i)};
      #1;
      chk($sformatf("preload x%0d", i), readData[31:0], (i == 0) ? 32'h0 : 32'hDEADBEEF);
      chk($sformatf("preload x%0d", i + 1), readData[63:32], 32'hDEADBEEF);
    end

    // Leave a busy register behind before reset
    issueValid = 1'b1;
    issueAddr  = 5'd20;
    tick();
    idle();
    readAddr = {5'd0, 5'd20};
    #1;
    chk("preRstBusy20", {30'b0, readBusy}, 32'h1);

    // Reset pulse: outputs gated while rst is high
    rst = 1'b1;
    #1;
    chk("rstPulseReady", {31'b0, ready}, 32'h0);
    chk("rstPulseRd0", readData[31:0], 32'h0);
    chk("rstPulseBusy", {30'b0, readBusy}, 32'h0);
    tick();
    rst = 1'b0;
    waitReady(1'b1, n);
    chk("sweepLatency", n, 32);

    for (int i = 0; i < N; i += 2) begin
      readAddr = {5'(i + 1), 5'(i)};
      #1;
      chk($sformatf("swept x%0d", i), readData[31:0], 32'h0);
      chk($sformatf("swept x%0d", i + 1), readData[63:32], 32'h0);
      chk($sformatf("sweptBusy x%0d", i), {30'b0, readBusy}, 32'h0);
    end

    // Mid-sweep reset at index 10 restarts the full sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("midSweepNotReady", {31'b0, ready}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    waitReady(1'b0, n);
    chk("midSweepLatency", n, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
